// File: rtl/id_imm_stage.sv
// Decode/buffer stage: small FIFO of fetched instructions feeding the immediate extender.
// Optional macro SHAMT_IMM_EN routes sll/srl/sra shift amounts onto the immediate path.
module id_imm_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16,
  output logic        out_ext_sel,
  output logic        out_shamt_sel
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [31:0]      inst_q [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;
  logic [31:0]      head_inst;
  logic             sign_ext;

  // in_ready depends only on registered count, so no path from out_ready
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        inst_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        inst_q[wr_ptr] <= in_inst;
        pc_q[wr_ptr]   <= in_pc;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_inst  = inst_q[rd_ptr];
  assign out_pc     = pc_q[rd_ptr];
  assign out_opcode = head_inst[31:26];
  assign out_rs     = head_inst[25:21];
  assign out_rt     = head_inst[20:16];
  assign out_rd     = head_inst[15:11];
  assign out_funct  = head_inst[5:0];

  // Branches, arithmetic immediates and loads/stores take a signed offset
  always_comb begin
    sign_ext = 1'b0;
    case (head_inst[31:26])
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25,
      6'h28, 6'h29, 6'h2B: sign_ext = 1'b1;
      default:             sign_ext = 1'b0;
    endcase
  end

`ifdef SHAMT_IMM_EN
  logic is_shift;

  assign is_shift = (head_inst[31:26] == 6'h00) &&
                    ((head_inst[5:0] == 6'h00) || (head_inst[5:0] == 6'h02) ||
                     (head_inst[5:0] == 6'h03));

  // The cleared head after reset decodes as sll; only flag shifts that are really present
  assign out_shamt_sel = is_shift & out_valid;
  assign out_imm16     = is_shift ? {11'b0, head_inst[10:6]} : head_inst[15:0];
  assign out_ext_sel   = sign_ext & ~is_shift;
`else
  assign out_shamt_sel = 1'b0;
  assign out_imm16     = head_inst[15:0];
  assign out_ext_sel   = sign_ext;
`endif

endmodule

// File: tb/tb_id_imm_stage.sv
// Scoreboard bench for id_imm_stage: expected entries queued on push, compared on pop.
// Honours SHAMT_IMM_EN the same way the design does.
module tb_id_imm_stage;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [5:0]  out_opcode;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [4:0]  out_rd;
  logic [5:0]  out_funct;
  logic [15:0] out_imm16;
  logic        out_ext_sel;
  logic        out_shamt_sel;

  always #5 clk = ~clk;

  id_imm_stage #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_opcode   (out_opcode),
    .out_rs       (out_rs),
    .out_rt       (out_rt),
    .out_rd       (out_rd),
    .out_funct    (out_funct),
    .out_imm16    (out_imm16),
    .out_ext_sel  (out_ext_sel),
    .out_shamt_sel(out_shamt_sel)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  entry_t sb[$];
  int     n_checks = 0;
  int     n_fails  = 0;

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_sign_ext(input logic [5:0] op);
    logic [5:0] signed_ops [14] = '{6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h20,
                                    6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};
    foreach (signed_ops[k]) if (signed_ops[k] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_shift(input logic [31:0] inst);
`ifdef SHAMT_IMM_EN
    return (inst[31:26] == 6'h00) &&
           (inst[5:0] == 6'h00 || inst[5:0] == 6'h02 || inst[5:0] == 6'h03);
`else
    return 1'b0;
`endif
  endfunction

  task automatic checkOutput(input entry_t e);
    logic        sh;
    logic [15:0] imm;
    sh  = exp_shift(e.inst);
    imm = sh ? {11'b0, e.inst[10:6]} : e.inst[15:0];
    check1("pc",        out_pc,        e.pc);
    check1("opcode",    out_opcode,    e.inst[31:26]);
    check1("rs",        out_rs,        e.inst[25:21]);
    check1("rt",        out_rt,        e.inst[20:16]);
    check1("rd",        out_rd,        e.inst[15:11]);
    check1("funct",     out_funct,     e.inst[5:0]);
    check1("imm16",     out_imm16,     imm);
    check1("ext_sel",   out_ext_sel,   sh ? 1'b0 : exp_sign_ext(e.inst[31:26]));
    check1("shamt_sel", out_shamt_sel, sh);
  endtask

  // One clock step: drive inputs, check handshake and head against the model, then advance
  task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [31:0] pc,
                               input logic rdy, input logic fl, input logic rst);
    logic   do_pop;
    logic   do_push;
    entry_t e;
    in_valid  = v;
    in_inst   = inst;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
    rst_n     = ~rst;
    check1("in_ready",  in_ready,  sb.size() != DEPTH);
    check1("out_valid", out_valid, sb.size() != 0);
    if (rst || fl) begin
      sb.delete();
    end else begin
      do_pop  = (sb.size() != 0) && rdy;
      do_push = v && (sb.size() != DEPTH);
      if (do_pop) begin
        checkOutput(sb[0]);
        void'(sb.pop_front());
      end
      if (do_push) begin
        e.inst = inst;
        e.pc   = pc;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0]  ops [8] = '{6'h00, 6'h08, 6'h0C, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h3F};
    logic [5:0]  shfn [4] = '{6'h00, 6'h02, 6'h03, 6'h20};
    logic [31:0] r;
    logic [31:0] inst;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_inst   = '0;
    in_pc     = '0;
    out_ready = 1'b0;

    // Reset held two cycles
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check1("rst_out_valid", out_valid,     1'b0);
    check1("rst_in_ready",  in_ready,      1'b1);
    check1("rst_pc",        out_pc,        32'h0);
    check1("rst_opcode",    out_opcode,    6'h0);
    check1("rst_imm16",     out_imm16,     16'h0);
    check1("rst_ext_sel",   out_ext_sel,   1'b0);
    check1("rst_shamt_sel", out_shamt_sel, 1'b0);

    // addi into an empty buffer, popped the following edge
    applyStimulus(1'b1, 32'h2008FFFF, 32'h100, 1'b1, 1'b0, 1'b0);
    check1("t2_valid",   out_valid,   1'b1);
    check1("t2_imm16",   out_imm16,   16'hFFFF);
    check1("t2_ext_sel", out_ext_sel, 1'b1);
    check1("t2_rt",      out_rt,      5'd8);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    check1("t2_empty", out_valid, 1'b0);

    // Fill with ori, lw under backpressure; third instruction held until space
    applyStimulus(1'b1, 32'h350800FF, 32'h104, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8C090004, 32'h108, 1'b0, 1'b0, 1'b0);
    check1("t3_full_in_ready", in_ready,    1'b0);
    check1("t3_ori_ext_sel",   out_ext_sel, 1'b0);
    applyStimulus(1'b1, 32'h20100001, 32'h10C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20100001, 32'h10C, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h20100001, 32'h10C, 1'b1, 1'b0, 1'b0);
    check1("t3_lw_opcode",  out_opcode,  6'h23);
    check1("t3_lw_ext_sel", out_ext_sel, 1'b1);
    applyStimulus(1'b1, 32'h20100001, 32'h10C, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Flush on a full buffer with a new instruction offered
    applyStimulus(1'b1, 32'h24010011, 32'h200, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24020022, 32'h204, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h24030033, 32'h208, 1'b0, 1'b1, 1'b0);
    check1("t4_out_valid", out_valid, 1'b0);
    check1("t4_in_ready",  in_ready,  1'b1);
    applyStimulus(1'b1, 32'h30040044, 32'h300, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Streaming push+pop every cycle
    for (int i = 0; i < 16; i++) begin
      r    = $urandom();
      inst = {ops[i % 8], r[25:0]};
      if (ops[i % 8] == 6'h00) inst[5:0] = shfn[(i / 8) % 4];
      applyStimulus(1'b1, inst, 32'h400 + 32'(i * 4), 1'b1, 1'b0, 1'b0);
      check1("t5_valid", out_valid, 1'b1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // sll rd=8, rt=9, sa=4
    applyStimulus(1'b1, 32'h00094100, 32'h500, 1'b0, 1'b0, 1'b0);
    check1("t6_rd", out_rd, 5'd8);
    check1("t6_rt", out_rt, 5'd9);
`ifdef SHAMT_IMM_EN
    check1("t6_shamt_sel", out_shamt_sel, 1'b1);
    check1("t6_imm16",     out_imm16,     16'h0004);
`else
    check1("t6_shamt_sel", out_shamt_sel, 1'b0);
    check1("t6_imm16",     out_imm16,     16'h4100);
`endif
    check1("t6_ext_sel", out_ext_sel, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

    // Reset mid-stream (with flush also raised) drops everything and clears data
    applyStimulus(1'b1, 32'h8C0A0008, 32'h600, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'hAC0B000C, 32'h604, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h3C0C1234, 32'h608, 1'b0, 1'b1, 1'b1);
    check1("rst2_out_valid", out_valid,  1'b0);
    check1("rst2_in_ready",  in_ready,   1'b1);
    check1("rst2_opcode",    out_opcode, 6'h0);
    check1("rst2_pc",        out_pc,     32'h0);
    applyStimulus(1'b1, 32'h2D0D7FFF, 32'h700, 1'b1, 1'b0, 1'b0);

    // Bounded drain
    for (int i = 0; i < 8 && sb.size() != 0; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    end
    check1("final_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
